// File: rtl/tick_source_ctrl.sv
// -----------------------------------------------------------------------------
// tick_source_ctrl
//
// Produces the counter-advance tick (pgt_1hz) for the time counter chain from
// the 100 Hz system clock. There is no clock switching here. A run/hold FSM
// and an internal divide-by-DIV counter decide, every cycle, whether the next
// cycle carries a one-cycle tick enable.
//   SLOW : one tick every DIV cycles (1 Hz with DIV=100)
//   FAST : one tick every cycle
//
// Ports
//   clk100    in   system clock; the only clock in this block
//   reset     in   synchronous, active-high; overrides every other input
//   enablen   in   asynchronous switch, 1 = FAST request, 0 = SLOW request
//   start     in   run/resume request, sampled every cycle
//   stop      in   pause request, sampled every cycle; stop beats start
//   pgt_1hz   out  registered one-cycle tick enable for downstream counters
//   running   out  1 while in SLOW or FAST
//   fast_mode out  1 while in FAST
//   state     out  FSM state: IDLE=00 SLOW=01 FAST=10 HOLD=11
//
// Parameters
//   DIV   clk100 cycles per SLOW tick (>= 2)
//   CNT_W divider width, 2**CNT_W >= DIV
// -----------------------------------------------------------------------------
module tick_source_ctrl #(
  parameter int DIV   = 100,
  parameter int CNT_W = 7
) (
  input  logic       clk100,
  input  logic       reset,
  input  logic       enablen,
  input  logic       start,
  input  logic       stop,
  output logic       pgt_1hz,
  output logic       running,
  output logic       fast_mode,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SLOW = 2'b01,
    FAST = 2'b10,
    HOLD = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  state_t           cur_state;
  state_t           nxt_state;
  logic [CNT_W-1:0] div_cnt;
  logic [CNT_W-1:0] div_nxt;
  logic [CNT_W-1:0] cnt_inc;
  logic             en_meta;
  logic             en_s;
  logic             mode_last;      // 1 = last run state was FAST
  logic             mode_last_nxt;
  logic             tick_nxt;

  assign cnt_inc = (div_cnt == LAST) ? '0 : div_cnt + CNT_W'(1);

  // Next-state, divider and tick decisions. Mode decisions only ever look at
  // the synchronized switch en_s, never at the raw enablen pin.
  always_comb begin
    nxt_state     = cur_state;
    div_nxt       = div_cnt;
    mode_last_nxt = mode_last;
    // Stop in the current cycle suppresses the tick it would have produced,
    // so a tick can never land in the first HOLD cycle.
    tick_nxt      = ~stop & (((cur_state == SLOW) && (div_cnt == LAST)) ||
                             (cur_state == FAST));
    case (cur_state)
      IDLE: begin
        div_nxt = '0;
        if (start && !stop) nxt_state = en_s ? FAST : SLOW;
      end
      SLOW: begin
        mode_last_nxt = 1'b0;
        if (stop) begin
          // The stop cycle is still a SLOW cycle and counts toward the period.
          nxt_state = HOLD;
          div_nxt   = cnt_inc;
        end else if (en_s) begin
          nxt_state = FAST;
          div_nxt   = '0;
        end else begin
          div_nxt   = cnt_inc;
        end
      end
      FAST: begin
        mode_last_nxt = 1'b1;
        div_nxt       = '0;
        if (stop)       nxt_state = HOLD;
        else if (!en_s) nxt_state = SLOW;   // restarts a full DIV period
      end
      HOLD: begin
        // Divider is frozen while held. Resuming in the same mode continues
        // the interrupted period; resuming in the other mode starts afresh.
        if (start && !stop) begin
          nxt_state = en_s ? FAST : SLOW;
          if (en_s != mode_last) div_nxt = '0;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      cur_state <= IDLE;
      div_cnt   <= '0;
      en_meta   <= 1'b0;
      en_s      <= 1'b0;
      mode_last <= 1'b0;
      pgt_1hz   <= 1'b0;
      running   <= 1'b0;
      fast_mode <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      div_cnt   <= div_nxt;
      en_meta   <= enablen;
      en_s      <= en_meta;
      mode_last <= mode_last_nxt;
      pgt_1hz   <= tick_nxt;
      // Decoded from the next state so they line up with the state register.
      running   <= (nxt_state == SLOW) || (nxt_state == FAST);
      fast_mode <= (nxt_state == FAST);
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_tick_source_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tick_source_ctrl
//
// Drives tick_source_ctrl (DIV=4, plus a DIV=100 copy sharing the inputs)
// through directed scenarios and a randomized run. A behavioural model of the
// tick scheduler is stepped alongside the DUT and compared every cycle;
// directed scenarios additionally check hand-derived cycle numbers.
// Cycle numbering: inputs applied in cycle c take effect at the edge that
// ends cycle c; values observed after that edge belong to cycle c+1.
// -----------------------------------------------------------------------------
module tb_tick_source_ctrl;

  localparam int DIV = 4;

  localparam int M_IDLE = 0;
  localparam int M_SLOW = 1;
  localparam int M_FAST = 2;
  localparam int M_HOLD = 3;

  // ---------------- clock / reset ----------------
  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic       reset   = 1'b1;
  logic       enablen = 1'b0;
  logic       start   = 1'b0;
  logic       stop    = 1'b0;
  logic       pgt_1hz, running, fast_mode;
  logic [1:0] state;
  logic       pgt_100, running_100, fast_100;
  logic [1:0] state_100;

  tick_source_ctrl #(.DIV(DIV), .CNT_W(2)) dut (
    .clk100(clk100), .reset(reset), .enablen(enablen), .start(start),
    .stop(stop), .pgt_1hz(pgt_1hz), .running(running),
    .fast_mode(fast_mode), .state(state)
  );

  tick_source_ctrl #(.DIV(100), .CNT_W(7)) dut_100 (
    .clk100(clk100), .reset(reset), .enablen(enablen), .start(start),
    .stop(stop), .pgt_1hz(pgt_100), .running(running_100),
    .fast_mode(fast_100), .state(state_100)
  );

  // ---------------- reference model ----------------
  int m_mode      = M_IDLE;
  int m_phase     = 0;      // SLOW cycles elapsed in the current period
  bit m_last_fast = 1'b0;
  bit m_tick      = 1'b0;
  bit en_pipe[$];           // [0] = synchronized switch, [1] = first stage

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
    n_checks++;
    assert (obs === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, want);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit s, input bit p);
    bit en;
    en = en_pipe[0];
    if (r) begin
      m_mode = M_IDLE; m_phase = 0; m_last_fast = 1'b0; m_tick = 1'b0;
      en_pipe.delete(); en_pipe.push_back(1'b0); en_pipe.push_back(1'b0);
    end else begin
      m_tick = !p && ((m_mode == M_SLOW && m_phase == DIV - 1) || m_mode == M_FAST);
      if (m_mode == M_IDLE) begin
        if (s && !p) m_mode = en ? M_FAST : M_SLOW;
        m_phase = 0;
      end else if (m_mode == M_SLOW) begin
        m_last_fast = 1'b0;
        if (p) begin
          m_mode = M_HOLD; m_phase = (m_phase + 1) % DIV;
        end else if (en) begin
          m_mode = M_FAST; m_phase = 0;
        end else begin
          m_phase = (m_phase + 1) % DIV;
        end
      end else if (m_mode == M_FAST) begin
        m_last_fast = 1'b1;
        m_phase = 0;
        if (p) m_mode = M_HOLD;
        else if (!en) m_mode = M_SLOW;
      end else begin
        if (s && !p) begin
          if (en != m_last_fast) m_phase = 0;
          m_mode = en ? M_FAST : M_SLOW;
        end
      end
      void'(en_pipe.pop_front());
      en_pipe.push_back(e);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit e, input bit s, input bit p);
    reset = r; enablen = e; start = s; stop = p;
    @(posedge clk100);
    model_update(r, e, s, p);
    #1;
    cyc++;
    chk("m_pgt",     8'(pgt_1hz),   8'(m_tick));
    chk("m_state",   8'(state),     8'(m_mode));
    chk("m_running", 8'(running),   8'(m_mode == M_SLOW || m_mode == M_FAST));
    chk("m_fast",    8'(fast_mode), 8'(m_mode == M_FAST));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit en_r;
    en_pipe.push_back(1'b0); en_pipe.push_back(1'b0);

    // 1: reset held with start and enablen active
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("rst_state", 8'(state), 8'h00);
    chk("rst_pgt",   8'(pgt_1hz), 8'h00);
    chk("rst_pgt100", 8'(pgt_100), 8'h00);

    // 2: SLOW start, ticks at 5,9,13 (DIV=4) and 101,201 (DIV=100)
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 202; i++) begin
      step(1'b0, 1'b0, (i == 0), 1'b0);
      if (cyc == 1) chk("s2_state", 8'(state), 8'h01);
      if (cyc <= 14) chk("s2_tick", 8'(pgt_1hz), 8'(cyc == 5 || cyc == 9 || cyc == 13));
      chk("s2_tick100", 8'(pgt_100), 8'(cyc == 101 || cyc == 201));
    end

    // 3: SLOW -> FAST -> SLOW via the switch
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 29; i++) begin
      step(1'b0, (i >= 7 && i < 20), (i == 0), 1'b0);
      if (cyc == 9)  chk("s3_slow9", 8'(state), 8'h01);
      if (cyc == 10) chk("s3_fast10", 8'(state), 8'h02);
      if (cyc >= 11 && cyc <= 23) chk("s3_fast_tick", 8'(pgt_1hz), 8'h01);
      if (cyc == 23) chk("s3_slow23", 8'(state), 8'h01);
      if (cyc >= 24 && cyc <= 26) chk("s3_gap", 8'(pgt_1hz), 8'h00);
      if (cyc == 27) chk("s3_tick27", 8'(pgt_1hz), 8'h01);
    end

    // 4 + 5: hold with preserved count, resume into FAST, start+stop in HOLD
    step(1'b1, 1'b0, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 41; i++) begin
      step(1'b0, (i >= 18 && i < 29),
           (i == 0 || i == 14 || i == 22 || i == 28 || i == 32),
           (i == 3 || i == 17 || i == 26 || i == 28));
      if (cyc >= 4 && cyc <= 14) begin
        chk("s4_hold_state", 8'(state), 8'h03);
        chk("s4_hold_tick", 8'(pgt_1hz), 8'h00);
      end
      if (cyc == 15) chk("s4_resume", 8'(state), 8'h01);
      if (cyc == 15) chk("s4_no_runt", 8'(pgt_1hz), 8'h00);
      if (cyc == 16) chk("s4_tick16", 8'(pgt_1hz), 8'h01);
      if (cyc == 23) chk("s5_fast23", 8'(state), 8'h02);
      if (cyc == 24) chk("s5_tick24", 8'(pgt_1hz), 8'h01);
      if (cyc == 27) chk("s5_stop_tick", 8'(pgt_1hz), 8'h00);
      if (cyc == 29) chk("s5_startstop", 8'(state), 8'h03);
      if (cyc == 33) chk("s5_slow33", 8'(state), 8'h01);
      if (cyc >= 34 && cyc <= 36) chk("s5_full_div", 8'(pgt_1hz), 8'h00);
      if (cyc == 37) chk("s5_tick37", 8'(pgt_1hz), 8'h01);
    end

    // 6: reset in FAST mid-run, then a fresh SLOW start
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    cyc = 0;
    for (int i = 0; i < 14; i++) begin
      step((i == 5), (i < 5), (i == 0 || i == 7), 1'b0);
      if (cyc == 1) chk("s6_fast", 8'(state), 8'h02);
      if (cyc == 2) chk("s6_tick2", 8'(pgt_1hz), 8'h01);
      if (cyc == 6) begin
        chk("s6_rst_state", 8'(state), 8'h00);
        chk("s6_rst_pgt", 8'(pgt_1hz), 8'h00);
        chk("s6_rst_run", 8'(running), 8'h00);
        chk("s6_rst_fast", 8'(fast_mode), 8'h00);
      end
      if (cyc == 8) chk("s6_slow8", 8'(state), 8'h01);
      if (cyc >= 9 && cyc <= 11) chk("s6_gap", 8'(pgt_1hz), 8'h00);
      if (cyc == 12) chk("s6_tick12", 8'(pgt_1hz), 8'h01);
    end

    // Randomized run against the model
    en_r = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) en_r = ~en_r;
      step(($urandom_range(0, 149) == 0), en_r,
           ($urandom_range(0, 6) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
